// File: rtl/custom_axi_ip_sched.sv
// Round-robin scheduler sharing one custom_axi_ip engine among NUM_REQ requesters.
// Accepts one job at a time, waits for engine completion or abort, returns result to owner.
module custom_axi_ip_sched #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic                          rsp_err_o,
  output logic [DATA_WIDTH-1:0]         eng_din_o,
  output logic                          eng_enable_o,
  input  logic [DATA_WIDTH:0]           eng_dout_i,
  input  logic [1:0]                    eng_enable_i,
  output logic                          busy_o,
  output logic [7:0]                    err_cnt_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         rr_q, rr_d;
  logic [PW-1:0]         own_q, own_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  err_q, err_d;
  logic [7:0]            ecnt_q, ecnt_d;

  logic                  hit;
  logic [PW-1:0]         pick;
  logic [PW-1:0]         cand;

  // First valid requester at or after rr_q, wrapping.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PW'((int'(rr_q) + k) % NUM_REQ);
      if (!hit && req_valid_i[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    own_d   = own_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    res_d   = res_q;
    err_d   = err_q;
    ecnt_d  = ecnt_q;
    case (state_q)
      IDLE: begin
        if (hit) begin
          data_d  = req_data_i[pick*DATA_WIDTH +: DATA_WIDTH];
          own_d   = pick;
          rr_d    = PW'((int'(pick) + 1) % NUM_REQ);
          tmo_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        tmo_d = tmo_q + TW'(1);
        // Completion wins over a coincident timeout.
        if (eng_enable_i == 2'b01 && eng_dout_i[0]) begin
          res_d   = eng_dout_i[DATA_WIDTH:1];
          err_d   = 1'b0;
          state_d = RESP;
        end else if (eng_enable_i[1]
                     || tmo_q == TW'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (err_q && ecnt_q != 8'hFF) begin
          ecnt_d = ecnt_q + 8'd1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q    <= '0;
      own_q   <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      own_q   <= own_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      res_q   <= res_d;
      err_q   <= err_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign req_ready_o  = (state_q == IDLE && hit)
                        ? (NUM_REQ'(1) << pick) : '0;
  assign rsp_valid_o  = (state_q == RESP)
                        ? (NUM_REQ'(1) << own_q) : '0;
  assign rsp_data_o   = (state_q == RESP) ? res_q : '0;
  assign rsp_err_o    = (state_q == RESP) & err_q;
  assign eng_din_o    = data_q;
  assign eng_enable_o = (state_q == WAIT);
  assign busy_o       = (state_q != IDLE);
  assign err_cnt_o    = ecnt_q;

endmodule
